// File: rtl/uvma_clknrst_rst_seq_ctrl_pkg.sv
// Shared types and constants for the clknrst reset sequencer.
// State encoding, counter sizing helper and minimum phase length.
package uvma_clknrst_rst_seq_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HOLD,
      SETTLE,
      RELEASE,
      DONE
   } state_e;

   localparam int unsigned MIN_CNT = 1;

   function automatic int unsigned cnt_width(
      input int unsigned hold_w,
      input int unsigned gap_w,
      input int unsigned settle
   );
      int unsigned w;
      int unsigned sw;
      w  = (hold_w > gap_w) ? hold_w : gap_w;
      sw = unsigned'($clog2(settle + 1));
      if (sw > w) w = sw;
      return w;
   endfunction

endpackage

// File: rtl/uvma_clknrst_rst_seq_cnt.sv
// Loadable down-counter shared by the hold, settle and gap phases.
// Load wins over decrement; the count saturates at zero.
module uvma_clknrst_rst_seq_cnt #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt;

   // phase counter: reload on phase entry, count down otherwise
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/uvma_clknrst_rst_seq_ctrl.sv
// Reset / clock-enable sequencer for several downstream reset domains.
// Gate clocks for a hold time, settle, then release domains in order.
module uvma_clknrst_rst_seq_ctrl
   import uvma_clknrst_rst_seq_ctrl_pkg::*;
#(
   parameter int unsigned NUM_DOMAINS   = 3,
   parameter int unsigned HOLD_W        = 16,
   parameter int unsigned GAP_W         = 8,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start_i,
   input  logic [HOLD_W-1:0]      hold_cycles_i,
   input  logic [GAP_W-1:0]       gap_cycles_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   start_err_o,
   output logic [NUM_DOMAINS-1:0] domain_rst_o,
   output logic [NUM_DOMAINS-1:0] domain_clk_en_o
);

   localparam int unsigned CW =
      cnt_width(HOLD_W, GAP_W, SETTLE_CYCLES);
   localparam int unsigned IW =
      (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DOMAINS - 1);
   localparam logic [CW-1:0] SETTLE_M1 = CW'(SETTLE_CYCLES - 1);

   state_e           state;
   logic [GAP_W-1:0] gap_q;
   logic [IW-1:0]    idx;
   logic [IW-1:0]    idx_nxt;
   logic             cnt_load;
   logic             cnt_dec;
   logic             cnt_zero;
   logic [CW-1:0]    cnt_val;
   logic [CW-1:0]    hold_m1;
   logic [CW-1:0]    gap_m1;

   // zero counts behave as one cycle
   assign hold_m1 = (hold_cycles_i == '0) ? '0 :
                    CW'(hold_cycles_i) - CW'(MIN_CNT);
   assign gap_m1  = (gap_q == '0) ? '0 :
                    CW'(gap_q) - CW'(MIN_CNT);
   assign idx_nxt = idx + IW'(1);

   uvma_clknrst_rst_seq_cnt #(
      .W (CW)
   ) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   // counter reload at each phase entry, decrement within a phase
   always_comb begin
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      cnt_val  = hold_m1;
      unique case (state)
         IDLE: begin
            cnt_load = start_i;
         end
         HOLD: begin
            if (cnt_zero) begin
               cnt_load = 1'b1;
               cnt_val  = SETTLE_M1;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         SETTLE: begin
            if (cnt_zero) begin
               cnt_load = 1'b1;
               cnt_val  = gap_m1;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         RELEASE: begin
            if (idx != LAST_IDX) begin
               if (cnt_zero) begin
                  cnt_load = 1'b1;
                  cnt_val  = gap_m1;
               end else begin
                  cnt_dec = 1'b1;
               end
            end
         end
         default: begin
         end
      endcase
   end

   // sequencer FSM with registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         busy_o          <= 1'b0;
         done_o          <= 1'b0;
         start_err_o     <= 1'b0;
         domain_rst_o    <= '1;
         domain_clk_en_o <= '1;
         idx             <= '0;
         gap_q           <= '0;
      end else begin
         done_o      <= 1'b0;
         start_err_o <= start_i && (state != IDLE);
         unique case (state)
            IDLE: begin
               if (start_i) begin
                  state           <= HOLD;
                  busy_o          <= 1'b1;
                  domain_rst_o    <= '1;
                  domain_clk_en_o <= '0;
                  gap_q           <= gap_cycles_i;
                  idx             <= '0;
               end
            end
            HOLD: begin
               if (cnt_zero) begin
                  state           <= SETTLE;
                  domain_clk_en_o <= '1;
               end
            end
            SETTLE: begin
               if (cnt_zero) begin
                  state           <= RELEASE;
                  domain_rst_o[0] <= 1'b0;
                  idx             <= '0;
               end
            end
            RELEASE: begin
               if (idx == LAST_IDX) begin
                  state  <= DONE;
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
               end else if (cnt_zero) begin
                  domain_rst_o[idx_nxt] <= 1'b0;
                  idx                   <= idx_nxt;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uvma_clknrst_rst_seq_ctrl.sv
// Bench for the clknrst reset sequencer.
// Timeline model of each sequence plus directed literal checks.
module tb_uvma_clknrst_rst_seq_ctrl;

   localparam int N = 3;
   localparam int S = 2;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start_i = 1'b0;
   logic [15:0]  hold_cycles_i = '0;
   logic [7:0]   gap_cycles_i = '0;
   logic         busy_o;
   logic         done_o;
   logic         start_err_o;
   logic [N-1:0] domain_rst_o;
   logic [N-1:0] domain_clk_en_o;

   uvma_clknrst_rst_seq_ctrl #(
      .NUM_DOMAINS   (N),
      .HOLD_W        (16),
      .GAP_W         (8),
      .SETTLE_CYCLES (S)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .start_i         (start_i),
      .hold_cycles_i   (hold_cycles_i),
      .gap_cycles_i    (gap_cycles_i),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .start_err_o     (start_err_o),
      .domain_rst_o    (domain_rst_o),
      .domain_clk_en_o (domain_clk_en_o)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, got, exp, $time);
      end
   endtask

   // timeline model: edge index of the accepted start and its counts
   int cyc = 0;
   int e0 = 0;
   int mh = 1;
   int mg = 1;
   bit act = 0;
   bit armed = 0;
   bit err_exp = 0;

   function automatic int span();
      return mh + S + (N - 1) * mg + 1;
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         act = 0;
         err_exp = 0;
         armed = 1;
      end else begin
         err_exp = 0;
         if (start_i) begin
            if (act && (cyc <= e0 + span() + 1)) begin
               err_exp = 1;
            end else begin
               act = 1;
               e0 = cyc;
               mh = (hold_cycles_i == 0) ? 1 : int'(hold_cycles_i);
               mg = (gap_cycles_i == 0) ? 1 : int'(gap_cycles_i);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         logic [N-1:0] er;
         logic [N-1:0] ec;
         logic         eb;
         logic         ed;
         int           t;
         if (!act) begin
            er = '1;
            ec = '1;
            eb = 1'b0;
            ed = 1'b0;
         end else begin
            t = cyc - e0;
            ec = (t >= mh) ? '1 : '0;
            for (int k = 0; k < N; k++)
               er[k] = !(t >= mh + S + k * mg);
            eb = (t < span());
            ed = (t == span());
         end
         chk("m_rst", 32'(domain_rst_o), 32'(er));
         chk("m_clk_en", 32'(domain_clk_en_o), 32'(ec));
         chk("m_busy", 32'(busy_o), 32'(eb));
         chk("m_done", 32'(done_o), 32'(ed));
         chk("m_err", 32'(start_err_o), 32'(err_exp));
      end
   end

   int rel = 0;

   task automatic step();
      @(negedge clk);
      rel++;
   endtask

   task automatic step_to(input int t);
      while (rel < t) step();
   endtask

   task automatic launch(input int h, input int g);
      start_i = 1'b1;
      hold_cycles_i = 16'(h);
      gap_cycles_i = 8'(g);
      @(negedge clk);
      rel = 0;
      start_i = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("pwr_rst", 32'(domain_rst_o), 32'h7);
      chk("pwr_clk_en", 32'(domain_clk_en_o), 32'h7);
      chk("pwr_busy", 32'(busy_o), 32'h0);

      launch(4, 3);
      chk("b_clk_en_e0", 32'(domain_clk_en_o), 32'h0);
      chk("b_busy_e0", 32'(busy_o), 32'h1);
      chk("b_rst_e0", 32'(domain_rst_o), 32'h7);
      step_to(3);
      chk("b_clk_en_3", 32'(domain_clk_en_o), 32'h0);
      step_to(4);
      chk("b_clk_en_4", 32'(domain_clk_en_o), 32'h7);
      step_to(5);
      chk("b_rst_5", 32'(domain_rst_o), 32'h7);
      step_to(6);
      chk("b_rst_6", 32'(domain_rst_o), 32'h6);
      step_to(9);
      chk("b_rst_9", 32'(domain_rst_o), 32'h4);
      step_to(12);
      chk("b_rst_12", 32'(domain_rst_o), 32'h0);
      chk("b_done_12", 32'(done_o), 32'h0);
      step_to(13);
      chk("b_done_13", 32'(done_o), 32'h1);
      chk("b_busy_13", 32'(busy_o), 32'h0);
      step_to(14);
      chk("b_done_14", 32'(done_o), 32'h0);
      step_to(16);

      launch(0, 0);
      step_to(1);
      chk("z_clk_en_1", 32'(domain_clk_en_o), 32'h7);
      step_to(3);
      chk("z_rst_3", 32'(domain_rst_o), 32'h6);
      step_to(4);
      chk("z_rst_4", 32'(domain_rst_o), 32'h4);
      step_to(5);
      chk("z_rst_5", 32'(domain_rst_o), 32'h0);
      step_to(6);
      chk("z_done_6", 32'(done_o), 32'h1);
      step_to(8);

      launch(4, 3);
      step_to(5);
      start_i = 1'b1;
      hold_cycles_i = 16'd9;
      step_to(6);
      start_i = 1'b0;
      chk("e_err_6", 32'(start_err_o), 32'h1);
      chk("e_rst_6", 32'(domain_rst_o), 32'h6);
      step_to(7);
      chk("e_err_7", 32'(start_err_o), 32'h0);
      step_to(13);
      chk("e_done_13", 32'(done_o), 32'h1);
      step_to(15);

      launch(4, 3);
      step_to(10);
      chk("r_rst_10", 32'(domain_rst_o), 32'h4);
      reset = 1'b1;
      step_to(11);
      reset = 1'b0;
      chk("r_rst_11", 32'(domain_rst_o), 32'h7);
      chk("r_clk_en_11", 32'(domain_clk_en_o), 32'h7);
      chk("r_busy_11", 32'(busy_o), 32'h0);
      chk("r_done_11", 32'(done_o), 32'h0);
      step_to(14);
      launch(2, 1);
      step_to(7);
      chk("r2_done_7", 32'(done_o), 32'h1);
      step_to(9);

      launch(1, 2);
      step_to(8);
      chk("bb_done_8", 32'(done_o), 32'h1);
      step_to(9);
      launch(3, 1);
      chk("bb_err", 32'(start_err_o), 32'h0);
      chk("bb_rst", 32'(domain_rst_o), 32'h7);
      chk("bb_clk_en", 32'(domain_clk_en_o), 32'h0);
      chk("bb_busy", 32'(busy_o), 32'h1);
      step_to(12);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
